// File: rtl/booth_mul_sched_if.sv
// Bundle of requester, response and multiplier-core signals for booth_mul_sched.
// slave = the scheduler side, master = the environment driving it.
interface booth_mul_sched_if #(
   parameter int WIDTH = 8
);
   logic               req0_valid;
   logic               req0_ready;
   logic [WIDTH-1:0]   req0_m;
   logic [WIDTH-1:0]   req0_q;
   logic               req1_valid;
   logic               req1_ready;
   logic [WIDTH-1:0]   req1_m;
   logic [WIDTH-1:0]   req1_q;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [2*WIDTH-1:0] rsp_prod;
   logic               rsp_id;
   logic               rsp_err;
   logic               mul_begin;
   logic               mul_lock;
   logic [WIDTH-1:0]   mul_inbus;
   logic [WIDTH-1:0]   mul_outbus;
   logic               mul_end;
   logic               busy;

   modport slave (
      input  req0_valid, req0_m, req0_q,
      input  req1_valid, req1_m, req1_q,
      input  rsp_ready, mul_outbus, mul_end,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_prod, rsp_id, rsp_err,
      output mul_begin, mul_lock, mul_inbus, busy
   );

   modport master (
      output req0_valid, req0_m, req0_q,
      output req1_valid, req1_m, req1_q,
      output rsp_ready, mul_outbus, mul_end,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_prod, rsp_id, rsp_err,
      input  mul_begin, mul_lock, mul_inbus, busy
   );
endinterface

// File: rtl/booth_mul_sched.sv
// Two-requester round-robin scheduler in front of a shared serial Booth multiplier core.
// Loads multiplicand then multiplier, waits for the core, collects the product bytes.
module booth_mul_sched #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64,
   parameter int TO_W    = 7
) (
   input logic              clk,
   input logic              rst_n,
   booth_mul_sched_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD_M, LOAD_Q, WAIT, CAP_LO, RESP} state_t;

   state_t                state, state_nxt;
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0][WIDTH-1:0] req_m;
   logic [1:0][WIDTH-1:0] req_q;
   logic                  gnt;
   logic                  accept;
   logic                  timer_exp;
   logic [WIDTH-1:0]      m_r;
   logic [WIDTH-1:0]      q_r;
   logic [2*WIDTH-1:0]    prod_r;
   logic                  id_r;
   logic                  err_r;
   logic                  last_grant;
   logic [TO_W-1:0]       timer;

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign req_m     = {bus.req1_m, bus.req0_m};
   assign req_q     = {bus.req1_q, bus.req0_q};

   // On a tie the requester not served last wins; otherwise the lone valid one.
   assign gnt       = (&req_valid) ? ~last_grant : ~req_valid[0];
   assign timer_exp = (timer == TO_W'(TIMEOUT - 1));
   assign accept    = |req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (rst_n && (|req_valid)) begin
               req_ready[gnt] = 1'b1;
               state_nxt      = LOAD_M;
            end
         end
         LOAD_M: state_nxt = LOAD_Q;
         LOAD_Q: state_nxt = WAIT;
         WAIT: begin
            if (bus.mul_end)    state_nxt = CAP_LO;
            else if (timer_exp) state_nxt = RESP;
         end
         CAP_LO: state_nxt = RESP;
         RESP: begin
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r        <= '0;
         q_r        <= '0;
         prod_r     <= '0;
         id_r       <= 1'b0;
         err_r      <= 1'b0;
         last_grant <= 1'b1;
         timer      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  m_r  <= req_m[gnt];
                  q_r  <= req_q[gnt];
                  id_r <= gnt;
               end
            end
            LOAD_Q: timer <= '0;
            WAIT: begin
               // A completion landing on the last allowed cycle still counts.
               if (bus.mul_end) begin
                  prod_r[2*WIDTH-1:WIDTH] <= bus.mul_outbus;
               end else if (timer_exp) begin
                  err_r  <= 1'b1;
                  prod_r <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            CAP_LO: prod_r[WIDTH-1:0] <= bus.mul_outbus;
            RESP: begin
               if (bus.rsp_ready) begin
                  last_grant <= id_r;
                  err_r      <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready = req_ready[0];
   assign bus.req1_ready = req_ready[1];
   assign bus.mul_begin  = (state == LOAD_M);
   assign bus.mul_lock   = (state == LOAD_M) || (state == LOAD_Q) ||
                           (state == WAIT)   || (state == CAP_LO);
   assign bus.mul_inbus  = (state == LOAD_M) ? m_r :
                           (state == LOAD_Q) ? q_r : '0;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_prod   = (state == RESP) ? prod_r : '0;
   assign bus.rsp_id     = (state == RESP) && id_r;
   assign bus.rsp_err    = (state == RESP) && err_r;
   assign bus.busy       = (state != IDLE);

   a_one_ready: assert property (@(posedge clk) disable iff (!rst_n) !(&req_ready));
   a_begin_pulse: assert property (@(posedge clk) disable iff (!rst_n)
                                   bus.mul_begin |=> !bus.mul_begin);
endmodule

// File: tb/tb_booth_mul_sched.sv
// Randomized bench for booth_mul_sched: behavioural core model plus a spec-level
// reference for grant order, latency, product and timeout.
module tb_booth_mul_sched;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 64;
   localparam int TO_W    = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   booth_mul_sched_if #(.WIDTH(WIDTH)) bus ();

   booth_mul_sched #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic             v  [2];
   logic [WIDTH-1:0] om [2];
   logic [WIDTH-1:0] oq [2];
   logic             lg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive();
      bus.req0_valid = v[0];
      bus.req0_m     = om[0];
      bus.req0_q     = oq[0];
      bus.req1_valid = v[1];
      bus.req1_m     = om[1];
      bus.req1_q     = oq[1];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: k = WAIT cycles before the core completes, to = core never
   // completes, bp = cycles of response backpressure, hold = granted requester keeps
   // valid with fresh operands, rst_at = cycle after accept at which reset pulses.
   task automatic txn(input int k, input bit to, input int bp, input bit hold,
                      input int rst_at, input string nm);
      logic                      g;
      logic [WIDTH-1:0]          em, eq;
      logic signed [2*WIDTH-1:0] ep;
      logic [2*WIDTH+1:0]        snap;
      int                        c, nbeg;
      bit                        bad;

      drive();
      #1;
      g = (v[0] && v[1]) ? ~lg : ~v[0];
      chk({nm, " grant"}, {bus.req1_ready, bus.req0_ready}, g ? 2'b10 : 2'b01);
      em = om[g];
      eq = oq[g];
      ep = $signed(em) * $signed(eq);
      tick();
      if (hold) begin
         om[g] = WIDTH'($urandom);
         oq[g] = WIDTH'($urandom);
      end else begin
         v[g] = 1'b0;
      end
      drive();

      bad  = 0;
      nbeg = 0;
      for (c = 1; c < 400; c++) begin
         if (rst_at != 0 && c == rst_at) begin
            bus.mul_end = 1'b0;
            rst_n = 1'b0;
            #1;
            chk({nm, " rst outs"},
                {bus.mul_begin, bus.mul_lock, bus.mul_inbus, bus.rsp_valid, bus.rsp_prod,
                 bus.rsp_id, bus.rsp_err, bus.busy, bus.req0_ready, bus.req1_ready}, '0);
            tick();
            rst_n = 1'b1;
            lg    = 1'b1;
            return;
         end
         if (bus.rsp_valid) break;
         if (c == 1) chk({nm, " load m"}, {bus.mul_begin, bus.mul_inbus}, {1'b1, em});
         if (c == 2) chk({nm, " load q"}, {bus.mul_begin, bus.mul_inbus}, {1'b0, eq});
         nbeg += int'(bus.mul_begin);
         if (!bus.mul_lock || !bus.busy || bus.req0_ready || bus.req1_ready) bad = 1;
         if (c >= 3 && bus.mul_inbus != '0) bad = 1;
         if (!to && c == 3 + k) begin
            bus.mul_end    = 1'b1;
            bus.mul_outbus = ep[2*WIDTH-1:WIDTH];
         end else begin
            bus.mul_end    = 1'b0;
            bus.mul_outbus = (!to && c == 4 + k) ? ep[WIDTH-1:0] : WIDTH'($urandom);
         end
         tick();
      end
      bus.mul_end = 1'b0;
      if (to) ep = '0;

      chk({nm, " latency"}, c, to ? 3 + TIMEOUT : 5 + k);
      chk({nm, " rsp"}, {bus.rsp_err, bus.rsp_id, bus.rsp_prod}, {to, g, ep});
      chk({nm, " busy phase"}, {bad, bus.mul_lock, bus.busy}, 3'b001);
      chk({nm, " begin count"}, nbeg, 1);

      snap = {bus.rsp_err, bus.rsp_id, bus.rsp_prod};
      bad  = 0;
      for (int i = 0; i < bp; i++) begin
         bus.rsp_ready  = 1'b0;
         bus.mul_end    = 1'($urandom);
         bus.mul_outbus = WIDTH'($urandom);
         tick();
         if (!bus.rsp_valid || bus.mul_lock || bus.req0_ready || bus.req1_ready ||
             {bus.rsp_err, bus.rsp_id, bus.rsp_prod} !== snap) bad = 1;
      end
      if (bp > 0) chk({nm, " backpressure"}, bad, 0);
      bus.rsp_ready = 1'b1;
      bus.mul_end   = 1'b0;
      tick();
      bus.rsp_ready = 1'b0;
      lg = g;
      chk({nm, " back to idle"}, {bus.rsp_valid, bus.busy}, 2'b00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      v  = '{1'b0, 1'b0};
      om = '{'0, '0};
      oq = '{'0, '0};
      lg = 1'b1;
      drive();
      bus.rsp_ready  = 1'b0;
      bus.mul_end    = 1'b0;
      bus.mul_outbus = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset outs",
          {bus.mul_begin, bus.mul_lock, bus.mul_inbus, bus.rsp_valid, bus.rsp_prod,
           bus.rsp_id, bus.rsp_err, bus.busy, bus.req0_ready, bus.req1_ready}, '0);
      rst_n = 1'b1;
      tick();

      v[0] = 1'b1; om[0] = 8'h05; oq[0] = 8'hFD;
      txn(8, 0, 0, 0, 0, "single");

      // Spurious completion while idle must not start anything.
      bus.mul_end = 1'b1;
      tick();
      bus.mul_end = 1'b0;
      chk("idle mul_end", {bus.busy, bus.mul_lock, bus.rsp_valid}, 3'b000);

      // Reset pulse in WAIT, then the first tie must go to requester 0.
      v[0] = 1'b1; om[0] = WIDTH'($urandom); oq[0] = WIDTH'($urandom);
      txn(10, 0, 0, 0, 5, "rst wait");
      v[0] = 1'b1; v[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         om[i] = WIDTH'($urandom);
         oq[i] = WIDTH'($urandom);
      end
      for (int i = 0; i < 4; i++) txn($urandom_range(0, 6), 0, 0, 1, 0, "contend");

      v[1] = 1'b0;
      v[0] = 1'b1; om[0] = WIDTH'($urandom); oq[0] = WIDTH'($urandom);
      txn(0, 1, 0, 0, 0, "timeout");
      v[1] = 1'b1; om[1] = 8'h80; oq[1] = 8'h80;
      txn(2, 0, 0, 0, 0, "after to");

      v[0] = 1'b1; om[0] = 8'h7F; oq[0] = 8'h81;
      txn(3, 0, 5, 0, 0, "backpress");

      v[1] = 1'b1; om[1] = 8'hFF; oq[1] = 8'hFF;
      txn(TIMEOUT - 1, 0, 1, 0, 0, "end at limit");

      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!v[i] || $urandom_range(0, 1) == 1) begin
               v[i]  = 1'($urandom);
               om[i] = WIDTH'($urandom);
               oq[i] = WIDTH'($urandom);
            end
         end
         if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1'b1;
         txn($urandom_range(0, TIMEOUT - 1), $urandom_range(0, 5) == 0,
             $urandom_range(0, 3), 1'($urandom), 0, "random");
      end

      v = '{1'b0, 1'b0};
      drive();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Scheduler that shares one Booth multiplier core between two requesters.
- Arbitrates round-robin between them and sequences the core's serial load: multiplicand, then multiplier, over the shared input bus.
- Holds the core's lock for the whole transaction and collects the 2*WIDTH product from the core's output bus.
- Returns the product, with requester id and a timeout-error flag, on a valid/ready response channel.

Parameters:
- WIDTH, 8, operand width; matches the core bus width.
- TIMEOUT, 64, maximum cycles spent in WAIT before abort; must be >= 2.
- TO_W, 7, timer width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_m  in  WIDTH  requester 0 multiplicand.
- req0_q  in  WIDTH  requester 0 multiplier.
- req1_valid, req1_ready, req1_m, req1_q  same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_prod  out  2*WIDTH  signed product {high, low}.
- rsp_id  out  1  index of the requester served.
- rsp_err  out  1  1 = core timed out; rsp_prod = 0.
- mul_begin  out  1  core start pulse.
- mul_lock  out  1  core ownership held.
- mul_inbus  out  WIDTH  operand byte to the core.
- mul_outbus  in  WIDTH  product byte from the core.
- mul_end  in  1  core completion pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, LOAD_M, LOAD_Q, WAIT, CAP_LO, RESP. Encoding is free.
- All core-side outputs and rsp_* are decoded from registered state and registered data only. There is no combinational path from mul_* inputs to outputs.
- Reset (asynchronous, rst_n=0) forces:
  - state = IDLE, takes effect immediately even mid-transaction;
  - all outputs = 0, so mul_lock drops at once;
  - last_grant = 1, so requester 0 wins the first tie.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, it goes to the one that is not last_grant.
  - reqN_ready = 1 combinationally for the granted requester only, and only in IDLE. The handshake completes in that same cycle.
  - On handshake, latch m, q and id, then go to LOAD_M.
  - mul_end in IDLE is ignored.
- LOAD_M: mul_begin=1, mul_lock=1, mul_inbus=latched m. Go to LOAD_Q.
- LOAD_Q: mul_lock=1, mul_inbus=latched q, timer cleared to 0. Go to WAIT.
- WAIT: mul_lock=1, mul_inbus=0.
  - If mul_end=1: capture mul_outbus into high byte, go to CAP_LO.
  - Else if timer == TIMEOUT-1: set err=1, clear product to 0, go to RESP.
  - Else timer increments.
  - mul_end has priority over timeout when both occur in the same cycle.
- CAP_LO: mul_lock=1. Capture mul_outbus into low byte (the core presents the low byte the cycle after mul_end). Go to RESP.
- RESP:
  - mul_lock=0, rsp_valid=1.
  - rsp_prod, rsp_id and rsp_err are stable until rsp_ready=1.
  - On handshake: last_grant = id, err cleared, go to IDLE.
  - New requests are accepted no earlier than the cycle after the response handshake. Reqs are never ready outside IDLE.
- Latency: accept at cycle t, mul_begin at t+1, mul_end at t+3+k, rsp_valid from t+5+k.
- mul_inbus = 0 whenever it is not in LOAD_M or LOAD_Q.
- mul_begin is exactly one cycle per transaction.

Test Plan:
- Single transaction: req0 m=0x05, q=0xFD. Core model returns 0xFF, 0xF1 with k=8 → req0_ready at t, mul_begin at t+1 with inbus 0x05, inbus 0xFD at t+2, rsp_prod=0xFFF1, id=0, err=0, rsp_valid at t+13.
- Contention and fairness: both requesters hold valid continuously for 4 transactions → grant order 0,1,0,1. A non-granted ready is never high. Each rsp_id matches its operands.
- Timeout: core never asserts mul_end → WAIT lasts exactly TIMEOUT cycles, then rsp_err=1 and rsp_prod=0. Next request proceeds normally.
- Backpressure: rsp_ready low for 5 cycles → rsp fields stable, no req*_ready, mul_lock=0 throughout RESP.
- Reset in WAIT: rst_n low for 1 cycle → all outputs 0 immediately and IDLE. First tie after reset grants requester 0.
- Spurious mul_end in IDLE and in RESP → ignored, no state change. mul_end in the same cycle as timer = TIMEOUT-1 → product captured, err=0.
